// File: rtl/register_file_multi_way_1w_multi_port_read_be_if.sv
// Bus interface for register_file_multi_way_1w_multi_port_read_be.
// Groups the flush, read-port and write-port signals.
//   master : requester side (drives Flush, Read*, Write*, samples ReadData/ReadValid)
//   slave  : register file side
// ReadData/ReadValid are indexed [way][port].
interface register_file_multi_way_1w_multi_port_read_be_if #(
  parameter int unsigned NB_WAYS     = 4,
  parameter int unsigned WADDR_WIDTH = 5,
  parameter int unsigned WDATA_WIDTH = 64,
  parameter int unsigned RDATA_WIDTH = 32,
  parameter int unsigned N_READ      = 4
);
  localparam int unsigned RATIO       = WDATA_WIDTH / RDATA_WIDTH;
  localparam int unsigned RADDR_WIDTH = WADDR_WIDTH + $clog2(RATIO);

  logic                                             Flush;
  logic [N_READ-1:0]                                ReadEnable;
  logic [N_READ-1:0][RADDR_WIDTH-1:0]               ReadAddr;
  logic [NB_WAYS-1:0][N_READ-1:0][RDATA_WIDTH-1:0]  ReadData;
  logic [NB_WAYS-1:0][N_READ-1:0]                   ReadValid;
  logic                                             WriteEnable;
  logic [NB_WAYS-1:0]                               WriteWay;
  logic [WADDR_WIDTH-1:0]                           WriteAddr;
  logic [WDATA_WIDTH-1:0]                           WriteData;
  logic [WDATA_WIDTH/8-1:0]                         WriteBE;

  modport master (
    output Flush, ReadEnable, ReadAddr, WriteEnable, WriteWay, WriteAddr, WriteData, WriteBE,
    input  ReadData, ReadValid
  );

  modport slave (
    input  Flush, ReadEnable, ReadAddr, WriteEnable, WriteWay, WriteAddr, WriteData, WriteBE,
    output ReadData, ReadValid
  );
endinterface

// File: rtl/register_file_multi_way_1w_multi_port_read_be.sv
// Multi-way flip-flop register file: one wide write port (multi-hot way select, byte
// enables, registered 2-stage write), N_READ narrow read ports returning one subword
// from every way, per-line valid bits, flush and synchronous active-high reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - slave modport: Flush, ReadEnable/ReadAddr -> ReadData/ReadValid (1-cycle
//          latency from registered address), WriteEnable/WriteWay/WriteAddr/WriteData/WriteBE
module register_file_multi_way_1w_multi_port_read_be #(
  parameter int unsigned NB_WAYS     = 4,
  parameter int unsigned WADDR_WIDTH = 5,
  parameter int unsigned WDATA_WIDTH = 64,
  parameter int unsigned RDATA_WIDTH = 32,
  parameter int unsigned N_READ      = 4,
  parameter bit          BYPASS      = 1'b1
) (
  input logic clk,
  input logic rst,
  register_file_multi_way_1w_multi_port_read_be_if.slave bus
);
  localparam int unsigned NumLines   = 2 ** WADDR_WIDTH;
  localparam int unsigned Ratio      = WDATA_WIDTH / RDATA_WIDTH;
  localparam int unsigned SubW       = $clog2(Ratio);
  localparam int unsigned RaddrWidth = WADDR_WIDTH + SubW;
  localparam int unsigned NbBytes    = WDATA_WIDTH / 8;

  // Storage: data is never reset, only the valid bits are.
  logic [WDATA_WIDTH-1:0]             mem_q [NB_WAYS][NumLines];
  logic [NB_WAYS-1:0][NumLines-1:0]   valid_q;
  logic [N_READ-1:0][RaddrWidth-1:0]  raddr_q;

  // Pending (captured, not yet committed) write.
  logic                    pend_v_q;
  logic [NB_WAYS-1:0]      pend_way_q;
  logic [WADDR_WIDTH-1:0]  pend_addr_q;
  logic [WDATA_WIDTH-1:0]  pend_data_q;
  logic [NbBytes-1:0]      pend_be_q;
  logic [WDATA_WIDTH-1:0]  pend_mask;

  logic capture;
  logic commit;
  logic [NB_WAYS-1:0][WDATA_WIDTH-1:0] commit_line;

  // A write with no way or no byte selected has no effect at all, so it is never captured.
  assign capture = bus.WriteEnable & (|bus.WriteWay) & (|bus.WriteBE);
  assign commit  = pend_v_q & ~bus.Flush;

  for (genvar b = 0; b < NbBytes; b++) begin : g_mask
    assign pend_mask[b*8 +: 8] = {8{pend_be_q[b]}};
  end

  // An invalid line's old bytes are treated as zero, so a partial write into an
  // invalid line yields the same value as the forwarded view and never exposes stale data.
  for (genvar w = 0; w < NB_WAYS; w++) begin : g_commit
    logic [WDATA_WIDTH-1:0] old_line;
    assign old_line       = valid_q[w][pend_addr_q] ? mem_q[w][pend_addr_q] : '0;
    assign commit_line[w] = (pend_data_q & pend_mask) | (old_line & ~pend_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      raddr_q     <= '0;
      pend_v_q    <= 1'b0;
      pend_way_q  <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_be_q   <= '0;
    end else begin
      pend_v_q <= capture;
      if (capture) begin
        pend_way_q  <= bus.WriteWay;
        pend_addr_q <= bus.WriteAddr;
        pend_data_q <= bus.WriteData;
        pend_be_q   <= bus.WriteBE;
      end
      for (int unsigned z = 0; z < N_READ; z++) begin
        if (bus.ReadEnable[z]) raddr_q[z] <= bus.ReadAddr[z];
      end
      if (bus.Flush) begin
        valid_q <= '0;
      end else if (pend_v_q) begin
        for (int unsigned w = 0; w < NB_WAYS; w++) begin
          if (pend_way_q[w]) valid_q[w][pend_addr_q] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NB_WAYS; w++) begin
      if (!rst && commit && pend_way_q[w]) mem_q[w][pend_addr_q] <= commit_line[w];
    end
  end

  // Read path: combinational from the registered address.
  logic [NB_WAYS-1:0][N_READ-1:0][RDATA_WIDTH-1:0] rd_data;
  logic [NB_WAYS-1:0][N_READ-1:0]                  rd_valid;

  for (genvar z = 0; z < N_READ; z++) begin : g_port
    logic [WADDR_WIDTH-1:0] line;
    logic [31:0]            sub_off;

    assign line    = raddr_q[z][RaddrWidth-1 -: WADDR_WIDTH];
    assign sub_off = 32'(raddr_q[z] & RaddrWidth'(Ratio - 1)) * RDATA_WIDTH;

    for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
      logic                   hit;
      logic                   line_v;
      logic [WDATA_WIDTH-1:0] base;
      logic [WDATA_WIDTH-1:0] line_data;

      assign hit       = BYPASS && pend_v_q && pend_way_q[w] && (pend_addr_q == line);
      assign line_v    = valid_q[w][line] | hit;
      assign base      = valid_q[w][line] ? mem_q[w][line] : '0;
      // base is zero when the line is invalid, so line_data is zero whenever line_v is 0.
      assign line_data = hit ? ((pend_data_q & pend_mask) | (base & ~pend_mask)) : base;

      assign rd_data[w][z]  = line_data[sub_off +: RDATA_WIDTH];
      assign rd_valid[w][z] = line_v;
    end
  end

  assign bus.ReadData  = rd_data;
  assign bus.ReadValid = rd_valid;
endmodule

// File: tb/tb_register_file_multi_way_1w_multi_port_read_be.sv
module tb_register_file_multi_way_1w_multi_port_read_be;
  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  register_file_multi_way_1w_multi_port_read_be_if bus1 ();
  register_file_multi_way_1w_multi_port_read_be_if bus0 ();

  register_file_multi_way_1w_multi_port_read_be #(.BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  register_file_multi_way_1w_multi_port_read_be #(.BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  // Both instances see identical stimulus.
  assign bus0.Flush       = bus1.Flush;
  assign bus0.ReadEnable  = bus1.ReadEnable;
  assign bus0.ReadAddr    = bus1.ReadAddr;
  assign bus0.WriteEnable = bus1.WriteEnable;
  assign bus0.WriteWay    = bus1.WriteWay;
  assign bus0.WriteAddr   = bus1.WriteAddr;
  assign bus0.WriteData   = bus1.WriteData;
  assign bus0.WriteBE     = bus1.WriteBE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [63:0] cm [4][32];
  bit        cv [4][32];
  bit        p_v;
  bit [3:0]  p_way;
  bit [4:0]  p_addr;
  bit [63:0] p_data;
  bit [7:0]  p_be;
  bit [5:0]  ra [4];

  function automatic bit [63:0] merge(input bit [63:0] nd, input bit [7:0] be,
                                      input bit [63:0] od);
    bit [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = be[b] ? nd[b*8 +: 8] : od[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (cv[w, l]) cv[w][l] = 1'b0;
      p_v = 1'b0;
      foreach (ra[z]) ra[z] = '0;
    end else begin
      if (p_v && !bus1.Flush) begin
        for (int w = 0; w < 4; w++) begin
          if (p_way[w]) begin
            cm[w][p_addr] = merge(p_data, p_be, cv[w][p_addr] ? cm[w][p_addr] : 64'd0);
            cv[w][p_addr] = 1'b1;
          end
        end
      end
      if (bus1.Flush) foreach (cv[w, l]) cv[w][l] = 1'b0;
      p_v = bus1.WriteEnable && (bus1.WriteWay != 0) && (bus1.WriteBE != 0);
      if (p_v) begin
        p_way  = bus1.WriteWay;
        p_addr = bus1.WriteAddr;
        p_data = bus1.WriteData;
        p_be   = bus1.WriteBE;
      end
      for (int z = 0; z < 4; z++) if (bus1.ReadEnable[z]) ra[z] = bus1.ReadAddr[z];
    end
  end

  task automatic exp_read(input bit byp, output logic [3:0][3:0][31:0] ed,
                          output logic [3:0][3:0] ev);
    int        line;
    int        sub;
    bit [63:0] ln;
    bit        v;
    ed = '0;
    ev = '0;
    for (int w = 0; w < 4; w++) begin
      for (int z = 0; z < 4; z++) begin
        line = int'(ra[z]) / 2;
        sub  = int'(ra[z]) % 2;
        v    = cv[w][line];
        ln   = v ? cm[w][line] : 64'd0;
        if (byp && p_v && p_way[w] && (int'(p_addr) == line)) begin
          ln = merge(p_data, p_be, ln);
          v  = 1'b1;
        end
        ev[w][z] = v;
        ed[w][z] = v ? ln[sub*32 +: 32] : 32'd0;
      end
    end
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0][3:0][31:0] ed;
    logic [3:0][3:0]       ev;
    if (chk_en) begin
      exp_read(1'b1, ed, ev);
      check("model_data_byp", bus1.ReadData, ed);
      check("model_valid_byp", 512'(bus1.ReadValid), 512'(ev));
      exp_read(1'b0, ed, ev);
      check("model_data_nobyp", bus0.ReadData, ed);
      check("model_valid_nobyp", 512'(bus0.ReadValid), 512'(ev));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus1.Flush       = 1'b0;
    bus1.ReadEnable  = '0;
    bus1.WriteEnable = 1'b0;
    bus1.WriteWay    = '0;
    bus1.WriteAddr   = '0;
    bus1.WriteData   = '0;
    bus1.WriteBE     = '0;
  endtask

  task automatic wr(input bit [4:0] a, input bit [3:0] way, input bit [63:0] d,
                    input bit [7:0] be);
    bus1.WriteEnable = 1'b1;
    bus1.WriteWay    = way;
    bus1.WriteAddr   = a;
    bus1.WriteData   = d;
    bus1.WriteBE     = be;
  endtask

  task automatic rd_all(input bit [5:0] a);
    bus1.ReadEnable = 4'hF;
    for (int z = 0; z < 4; z++) bus1.ReadAddr[z] = a;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus1.ReadAddr = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state, then read line 3 subword 1 everywhere.
    check("reset_valid", 512'(bus1.ReadValid), 512'd0);
    rst = 1'b0;
    rd_all(6'd7);
    @(negedge clk);
    check("t1_valid", 512'(bus1.ReadValid), 512'd0);
    check("t1_data", bus1.ReadData, 512'd0);

    // Full-line write to ways 0 and 2.
    idle();
    wr(5'd5, 4'b0101, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    idle();
    rd_all(6'd11);
    @(negedge clk);
    check("t2_w0_hi", 512'(bus1.ReadData[0][0]), 512'h11223344);
    check("t2_w2_hi", 512'(bus1.ReadData[2][3]), 512'h11223344);
    check("t2_w0_v", 512'(bus1.ReadValid[0][0]), 512'd1);
    check("t2_w1_v", 512'(bus1.ReadValid[1][0]), 512'd0);
    check("t2_w3_d", 512'(bus1.ReadData[3][1]), 512'd0);
    rd_all(6'd10);
    @(negedge clk);
    check("t2_w0_lo", 512'(bus1.ReadData[0][2]), 512'h55667788);

    // Partial byte-enable overwrite, observed forwarded and committed.
    idle();
    wr(5'd5, 4'b0101, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    bus1.ReadEnable  = 4'b0011;
    bus1.ReadAddr[0] = 6'd10;
    bus1.ReadAddr[1] = 6'd11;
    @(negedge clk);
    check("t3_fwd_byp", 512'(bus1.ReadData[0][0]), 512'hBBBBBBBB);
    check("t3_fwd_nobyp", 512'(bus0.ReadData[0][0]), 512'h55667788);
    idle();
    @(negedge clk);
    check("t3_sub0", 512'(bus0.ReadData[2][0]), 512'hBBBBBBBB);
    check("t3_sub1", 512'(bus0.ReadData[2][1]), 512'h11223344);

    // Forwarding versus committed-only visibility.
    idle();
    wr(5'd7, 4'b0010, 64'hCAFE, 8'hFF);
    rd_all(6'd14);
    @(negedge clk);
    check("t4_byp_d", 512'(bus1.ReadData[1][2]), 512'hCAFE);
    check("t4_byp_v", 512'(bus1.ReadValid[1][2]), 512'd1);
    check("t4_nobyp_v", 512'(bus0.ReadValid[1][2]), 512'd0);
    idle();
    @(negedge clk);
    check("t4_nobyp_d2", 512'(bus0.ReadData[1][2]), 512'hCAFE);
    check("t4_nobyp_v2", 512'(bus0.ReadValid[1][2]), 512'd1);

    // Flush drops the pending write to line 2 but keeps the new write to line 1.
    for (int l = 0; l < 4; l++) begin
      idle();
      wr(5'(l), 4'hF, {32'hF000_0000 + 32'(l), 32'h0F00_0000 + 32'(l)}, 8'hFF);
      @(negedge clk);
    end
    wr(5'd2, 4'hF, 64'h2222_2222_2222_2222, 8'hFF);
    @(negedge clk);
    bus1.Flush = 1'b1;
    wr(5'd1, 4'hF, 64'h1111_0000_1111_0001, 8'hFF);
    @(negedge clk);
    idle();
    bus1.ReadEnable  = 4'hF;
    bus1.ReadAddr[0] = 6'd2;
    bus1.ReadAddr[1] = 6'd4;
    bus1.ReadAddr[2] = 6'd0;
    bus1.ReadAddr[3] = 6'd6;
    @(negedge clk);
    check("t5_valid_byp", 512'(bus1.ReadValid), 512'h1111);
    check("t5_valid_nobyp", 512'(bus0.ReadValid), 512'h1111);
    check("t5_line1", 512'(bus1.ReadData[3][0]), 512'h1111_0001);

    // Random back-to-back traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      idle();
      bus1.ReadEnable = 4'($urandom);
      for (int z = 0; z < 4; z++) bus1.ReadAddr[z] = 6'($urandom);
      if ($urandom % 8 != 0 || i == 199) begin
        wr(5'(i % 32), 4'($urandom), {$urandom, $urandom},
           ($urandom % 4 == 0) ? 8'($urandom) : 8'hFF);
        if (i == 199) bus1.WriteWay = 4'hF;
      end
      if (i == 201) bus1.WriteEnable = 1'b0;
      bus1.Flush = ($urandom % 50 == 0);
      rst = (i == 200);
      @(negedge clk);
      if (i == 200 || i == 201) begin
        check("t6_rst_valid_byp", 512'(bus1.ReadValid), 512'd0);
        check("t6_rst_valid_nobyp", 512'(bus0.ReadValid), 512'd0);
      end
    end
    rst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
